fetch_sequencer: RTL and testbench

Multicycle fetch/decode/sequencing FSM for the 16-bit CPU. It fetches each instruction from unified memory at the current PC, latches it into the instruction register, and evaluates Bcond/Jcond against the ALU flags. It generates the enable, select, displacement and target controls consumed by the program counter, plus write strobes for the register file, flags register and memory.

---
 rtl/fetch_sequencer.sv | 105 ++++++++++
 tb/tb_fetch_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle fetch/decode/exec FSM driving PC, register-file, flags and memory controls.
// Every control output is registered for the state being entered; strobes are gated by stall.
module fetch_sequencer #(
   parameter int         DW       = 16,
   parameter logic [3:0] OP_BCOND = 4'b1100,
   parameter logic [3:0] OP_EXT   = 4'b0100
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic [DW-1:0] pc,
   input  logic [DW-1:0] mem_rdata,
   input  logic [4:0]    flags,
   input  logic [DW-1:0] rtgt_data,
   output logic [DW-1:0] ir,
   output logic          addr_sel,
   output logic          mem_we,
   output logic          reg_we,
   output logic          wb_sel,
   output logic          flags_we,
   output logic          pc_en,
   output logic [1:0]    pc_sel,
   output logic [DW-1:0] pc_imm,
   output logic [DW-1:0] pc_target,
   output logic [2:0]    state
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
   state_t state_q, state_d, state_nx;
   logic [DW-1:0] ir_q, ir_d, ir_nx;
   logic addr_sel_q, addr_sel_d, mem_we_q, mem_we_d, reg_we_q, reg_we_d;
   logic wb_sel_q, wb_sel_d, flags_we_q, flags_we_d, pc_en_q, pc_en_d;
   logic [1:0] pc_sel_q, pc_sel_d;
   logic [3:0] op, sub;
   logic is_bcond, is_ext, is_ld, is_st, is_jcond, is_cmp, is_alu, taken, pc_unused;
   logic [15:0] cond_vec;
   // The PC datapath owns all arithmetic on pc; it is not needed here.
   assign pc_unused = ^pc;
   // Decode looks at the word being latched into IR, so DECODE can already pick MEM vs EXEC.
   assign ir_nx    = state_q == DECODE ? mem_rdata : ir_q;
   assign op       = ir_nx[15:12];
   assign sub      = ir_nx[7:4];
   assign is_bcond = op == OP_BCOND;
   assign is_ext   = op == OP_EXT;
   assign is_ld    = is_ext && sub == 4'b0000;
   assign is_st    = is_ext && sub == 4'b0100;
   assign is_jcond = is_ext && sub == 4'b1100;
   assign is_cmp   = (op == 4'b0000 && sub == 4'b1011) || op == 4'b1011;
   assign is_alu   = !is_bcond && !is_jcond && !is_ld && !is_st;
   // flags = {C,L,F,Z,N}; entry i is the condition with code i.
   assign cond_vec = {1'b0, 1'b1,
                      flags[0] | flags[1], !flags[0] & !flags[1],
                      flags[3] | flags[1], !flags[3] & !flags[1],
                      !flags[2], flags[2], !flags[0], flags[0],
                      !flags[3], flags[3], !flags[4], flags[4],
                      !flags[1], flags[1]};
   assign taken    = cond_vec[ir_nx[11:8]] && (is_bcond || is_jcond);
   always_comb begin
      state_nx   = state_q == FETCH  ? DECODE :
                   state_q == DECODE ? ((is_ld || is_st) ? MEM : EXEC) :
                   (state_q == MEM && is_ld) ? WB : FETCH;
      state_d    = stall ? state_q : state_nx;
      ir_d       = stall ? ir_q : ir_nx;
      addr_sel_d = stall ? addr_sel_q : (state_nx == MEM || state_nx == WB);
      mem_we_d   = stall ? mem_we_q : (state_nx == MEM && is_st);
      reg_we_d   = stall ? reg_we_q : (state_nx == WB || (state_nx == EXEC && is_alu && !is_cmp));
      wb_sel_d   = stall ? wb_sel_q : state_nx == WB;
      flags_we_d = stall ? flags_we_q : (state_nx == EXEC && is_alu && !(is_ext && sub == 4'b1000));
      pc_en_d    = stall ? pc_en_q : (state_nx == DECODE || (state_nx == EXEC && taken));
      pc_sel_d   = stall ? pc_sel_q : (state_nx == EXEC && taken) ? (is_bcond ? 2'b01 : 2'b10) : 2'b00;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         ir_q       <= '0;
         addr_sel_q <= 1'b0;
         mem_we_q   <= 1'b0;
         reg_we_q   <= 1'b0;
         wb_sel_q   <= 1'b0;
         flags_we_q <= 1'b0;
         pc_en_q    <= 1'b0;
         pc_sel_q   <= 2'b00;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         addr_sel_q <= addr_sel_d;
         mem_we_q   <= mem_we_d;
         reg_we_q   <= reg_we_d;
         wb_sel_q   <= wb_sel_d;
         flags_we_q <= flags_we_d;
         pc_en_q    <= pc_en_d;
         pc_sel_q   <= pc_sel_d;
      end
   end
   assign ir        = ir_q;
   assign state     = state_q;
   assign addr_sel  = addr_sel_q;
   assign wb_sel    = wb_sel_q;
   assign pc_sel    = pc_sel_q;
   assign mem_we    = mem_we_q & ~stall;
   assign reg_we    = reg_we_q & ~stall;
   assign flags_we  = flags_we_q & ~stall;
   assign pc_en     = pc_en_q & ~stall;
   assign pc_imm    = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
   assign pc_target = rtgt_data + DW'(1);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed expectations for fetch_sequencer.
module tb_fetch_sequencer;
   logic        clk = 1'b0, rst = 1'b0, stall = 1'b0;
   logic [15:0] pc = '0, mem_rdata = '0, rtgt_data = '0;
   logic [4:0]  flags = '0;
   logic [15:0] ir, pc_imm, pc_target;
   logic        addr_sel, mem_we, reg_we, wb_sel, flags_we, pc_en;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   int checks = 0, errors = 0;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall), .pc(pc), .mem_rdata(mem_rdata),
      .flags(flags), .rtgt_data(rtgt_data), .ir(ir), .addr_sel(addr_sel),
      .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel), .flags_we(flags_we),
      .pc_en(pc_en), .pc_sel(pc_sel), .pc_imm(pc_imm), .pc_target(pc_target),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // strobes packed as {addr_sel, mem_we, reg_we, wb_sel, flags_we, pc_en}
   function automatic logic [5:0] ctl();
      return {addr_sel, mem_we, reg_we, wb_sel, flags_we, pc_en};
   endfunction

   initial begin
      rtgt_data = 16'hFFFF;
      #12;
      chk("rst_state", state, 0);
      chk("rst_ctl", ctl(), 6'b0);
      chk("rst_ir", ir, 0);
      chk("rst_pc_sel", pc_sel, 0);
      chk("rst_pc_imm", pc_imm, 0);
      chk("rst_pc_target", pc_target, 0);
      @(negedge clk);
      rst = 1'b1;
      pc = 16'h0000;
      mem_rdata = 16'h0512;
      #1;
      chk("add_fetch", state, 0);
      step();
      chk("add_decode", state, 1);
      chk("add_decode_ctl", ctl(), 6'b000001);
      chk("add_decode_sel", pc_sel, 2'b00);
      step();
      chk("add_exec", state, 2);
      chk("add_exec_ctl", ctl(), 6'b001010);
      chk("add_ir", ir, 16'h0512);
      step();
      chk("add_done", state, 0);
      chk("add_done_ctl", ctl(), 6'b0);

      mem_rdata = 16'hC0FC;
      flags = 5'b00010;
      step(); step();
      chk("beq_t_exec", state, 2);
      chk("beq_t_ctl", ctl(), 6'b000001);
      chk("beq_t_sel", pc_sel, 2'b01);
      chk("beq_t_imm", pc_imm, 16'hFFFC);
      step();
      chk("beq_t_done", state, 0);
      flags = 5'b00000;
      step(); step();
      chk("beq_nt_ctl", ctl(), 6'b0);
      step();

      mem_rdata = 16'h4EC3;
      rtgt_data = 16'h0040;
      step(); step();
      chk("juc_ctl", ctl(), 6'b000001);
      chk("juc_sel", pc_sel, 2'b10);
      chk("juc_target", pc_target, 16'h0041);
      rtgt_data = 16'hFFFF;
      #1;
      chk("juc_target_wrap", pc_target, 16'h0000);
      step();
      chk("juc_done", state, 0);

      mem_rdata = 16'h4102;
      step(); step();
      chk("ld_mem", state, 3);
      chk("ld_mem_ctl", ctl(), 6'b100000);
      step();
      chk("ld_wb", state, 4);
      chk("ld_wb_ctl", ctl(), 6'b101100);
      step();
      chk("ld_done", state, 0);
      chk("ld_done_ctl", ctl(), 6'b0);

      mem_rdata = 16'h4142;
      step(); step();
      chk("st_mem", state, 3);
      chk("st_mem_ctl", ctl(), 6'b110000);
      step();
      chk("st_done", state, 0);
      chk("st_done_ctl", ctl(), 6'b0);

      mem_rdata = 16'h0512;
      step(); step();
      chk("stl_exec", state, 2);
      stall = 1'b1;
      #1;
      chk("stl_gate", ctl(), 6'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stl_hold_state", state, 2);
         chk("stl_hold_ctl", ctl(), 6'b0);
      end
      stall = 1'b0;
      #1;
      chk("stl_release", ctl(), 6'b001010);
      step();
      chk("stl_after", state, 0);
      chk("stl_after_ctl", ctl(), 6'b0);

      mem_rdata = 16'h4102;
      step(); step();
      chk("rmid_mem", state, 3);
      rst = 1'b0;
      #1;
      chk("rmid_state", state, 0);
      chk("rmid_ctl", ctl(), 6'b0);
      chk("rmid_ir", ir, 0);
      step();
      rst = 1'b1;
      #1;
      chk("rmid_rel_state", state, 0);
      chk("rmid_rel_ctl", ctl(), 6'b0);
      step();
      chk("rmid_decode", state, 1);
      chk("rmid_decode_ctl", ctl(), 6'b000001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
